vlc_ac_scan_sequencer: RTL and testbench

//  Per-slice controller for the AC entropy path. Walks a slice's quantised coefficient RAM
//  in ProRes AC order: for scan index 1..63, for each block 0..nb-1. Feeds one coefficient
//  per cycle to the AC run coder and the AC level coder, and reinitialises their run state
//  at slice start. Sits between the quantiser coefficient buffer and the VLC/bit-packer

---
 rtl/vlc_pkg.sv | 34 +++
 rtl/vlc_scan_addr_gen.sv | 50 +++++
 rtl/vlc_ac_scan_sequencer.sv | 158 +++++++++++++++
 tb/tb_vlc_ac_scan_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared types and scan-order tables for the AC entropy path.
// Holds the FSM encoding and the ProRes progressive/interlaced scan tables.
package vlc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_SCAN,
      ST_DRAIN
   } state_e;

   localparam logic [5:0] SCAN_PROG [64] = '{
      6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
      6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
      6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
      6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
      6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
      6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
      6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   localparam logic [5:0] SCAN_INTL [64] = '{
      6'd0,  6'd8,  6'd1,  6'd9,  6'd16, 6'd24, 6'd17, 6'd25,
      6'd2,  6'd10, 6'd3,  6'd11, 6'd18, 6'd26, 6'd19, 6'd27,
      6'd32, 6'd40, 6'd33, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49,
      6'd42, 6'd35, 6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd59,
      6'd4,  6'd12, 6'd5,  6'd6,  6'd13, 6'd20, 6'd28, 6'd21,
      6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36, 6'd44, 6'd37,
      6'd30, 6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd60, 6'd53,
      6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
   };

endpackage

// File: rtl/vlc_scan_addr_gen.sv
// Scan-index / block counters and coefficient RAM address for the AC walk.
// Ports: clear (idx=1,blk=0), advance (step one read), nb, interlaced -> addr, last.
module vlc_scan_addr_gen
   import vlc_pkg::*;
#(
   parameter int BLK_W  = 6,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              advance,
   input  logic [BLK_W-1:0]  nb,
   input  logic              interlaced,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [5:0]       idx_q;
   logic [BLK_W-1:0] blk_q;
   logic             blk_wrap;
   logic [5:0]       scan;

   assign blk_wrap = (blk_q == nb - BLK_W'(1));
   assign last     = (idx_q == 6'd63) && blk_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q <= 6'd1;
         blk_q <= '0;
      end else if (clear) begin
         idx_q <= 6'd1;
         blk_q <= '0;
      end else if (advance) begin
         if (blk_wrap) begin
            blk_q <= '0;
            idx_q <= idx_q + 6'd1;
         end else begin
            blk_q <= blk_q + BLK_W'(1);
         end
      end
   end

   assign scan = interlaced ? SCAN_INTL[idx_q]
                            : SCAN_PROG[idx_q];

   // Block number sits directly above the 6-bit in-block offset.
   assign addr = {blk_q[ADDR_W-7:0], scan};

endmodule

// File: rtl/vlc_ac_scan_sequencer.sv
// Per-slice AC scan controller: walks coefficient RAM in ProRes AC order
// and feeds the run/level coders. Ports: start/abort/pause control, RAM read, coder feed.
module vlc_ac_scan_sequencer
   import vlc_pkg::*;
#(
   parameter int MAX_BLOCKS   = 32,
   parameter int BLK_W        = 6,
   parameter int ADDR_W       = 11,
   parameter int DRAIN_CYCLES = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [BLK_W-1:0]  num_blocks,
   input  logic              interlaced,
   input  logic              abort,
   input  logic              pause,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              coef_rd_en,
   output logic [ADDR_W-1:0] coef_rd_addr,
   input  logic [31:0]       coef_rd_data,
   output logic              coder_init,
   output logic              coder_en,
   output logic [31:0]       coder_coeff,
   output logic              coder_last
);

   localparam int DCW = $clog2(DRAIN_CYCLES + 2);

   state_e           state_q;
   state_e           state_d;
   logic [BLK_W-1:0] nb_q;
   logic             intl_q;
   logic             err_q;
   logic [DCW-1:0]   drain_cnt;
   logic             drain_done;
   logic             nb_ok;
   logic             accept;
   logic             rd_en;
   logic             ag_clear;
   logic             ag_last;
   logic [ADDR_W-1:0] ag_addr;
   logic             rd_en_d1;
   logic             last_d1;

   assign nb_ok  = (num_blocks != '0) &&
                   (num_blocks <= BLK_W'(MAX_BLOCKS));
   assign accept = (state_q == ST_IDLE) && start && !abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start && nb_ok) state_d = ST_INIT;
         ST_INIT:  state_d = ST_SCAN;
         ST_SCAN:  if (rd_en && ag_last) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_comb begin
      busy       = 1'b0;
      coder_init = 1'b0;
      rd_en      = 1'b0;
      drain_done = 1'b0;
      unique case (state_q)
         ST_IDLE: ;
         ST_INIT: begin
            busy       = 1'b1;
            coder_init = 1'b1;
         end
         ST_SCAN: begin
            busy  = 1'b1;
            rd_en = !pause && !abort;
         end
         ST_DRAIN: begin
            busy       = 1'b1;
            drain_done = (drain_cnt == DCW'(DRAIN_CYCLES + 1));
         end
         default: ;
      endcase
   end

   assign coef_rd_en   = rd_en;
   assign coef_rd_addr = rd_en ? ag_addr : '0;
   assign done         = (drain_done | err_q) & ~abort;
   assign cfg_err      = err_q & ~abort;

   // Counters idle at idx=1/blk=0 whenever not scanning.
   assign ag_clear = (state_q != ST_SCAN) || abort;

   vlc_scan_addr_gen #(
      .BLK_W  (BLK_W),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (ag_clear),
      .advance    (rd_en),
      .nb         (nb_q),
      .interlaced (intl_q),
      .addr       (ag_addr),
      .last       (ag_last)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nb_q   <= '0;
         intl_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         err_q <= accept && !nb_ok;
         if (accept && nb_ok) begin
            nb_q   <= num_blocks;
            intl_q <= interlaced;
         end
      end
   end

   // DRAIN entry is one cycle before coder_last, so done lands
   // DRAIN_CYCLES after coder_last at count DRAIN_CYCLES+1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                drain_cnt <= '0;
      else if (state_q != ST_DRAIN) drain_cnt <= '0;
      else                         drain_cnt <= drain_cnt + DCW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_en_d1    <= 1'b0;
         last_d1     <= 1'b0;
         coder_en    <= 1'b0;
         coder_last  <= 1'b0;
         coder_coeff <= '0;
      end else if (abort) begin
         rd_en_d1    <= 1'b0;
         last_d1     <= 1'b0;
         coder_en    <= 1'b0;
         coder_last  <= 1'b0;
         coder_coeff <= '0;
      end else begin
         rd_en_d1   <= rd_en;
         last_d1    <= rd_en && ag_last;
         coder_en   <= rd_en_d1;
         coder_last <= last_d1;
         if (rd_en_d1) coder_coeff <= coef_rd_data;
      end
   end

endmodule

// File: tb/tb_vlc_ac_scan_sequencer.sv
// Directed bench for vlc_ac_scan_sequencer with a synchronous RAM model.
// Scenario tasks log DUT activity on the falling edge and compare to hand values.
module tb_vlc_ac_scan_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [5:0]  num_blocks;
   logic        interlaced;
   logic        abort;
   logic        pause;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic        coef_rd_en;
   logic [10:0] coef_rd_addr;
   logic [31:0] coef_rd_data;
   logic        coder_init;
   logic        coder_en;
   logic [31:0] coder_coeff;
   logic        coder_last;

   logic [31:0] mem [2048];

   int prog_t [64] = '{
      0, 1, 8, 9, 2, 3,10,11,16,17,24,25,18,19,26,27,
      4, 5,12,20,13, 6, 7,14,21,28,29,22,15,23,30,31,
     32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,
     51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63};
   int intl_t [64] = '{
      0, 8, 1, 9,16,24,17,25, 2,10, 3,11,18,26,19,27,
     32,40,33,34,41,48,56,49,42,35,43,50,57,58,51,59,
      4,12, 5, 6,13,20,28,21,14, 7,15,22,29,36,44,37,
     30,23,31,38,45,52,60,53,46,39,47,54,61,62,55,63};

   int          rd_addr_q [$];
   int          rd_cyc_q  [$];
   int          en_cyc_q  [$];
   logic [31:0] coeff_q   [$];
   bit          last_q    [$];
   int          init_q    [$];
   int          done_q    [$];
   bit          err_log   [$];
   int          pause_rd;
   bit          busy_seen;

   int cyc    = 0;
   int passed = 0;
   int total  = 0;

   vlc_ac_scan_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .num_blocks   (num_blocks),
      .interlaced   (interlaced),
      .abort        (abort),
      .pause        (pause),
      .busy         (busy),
      .done         (done),
      .cfg_err      (cfg_err),
      .coef_rd_en   (coef_rd_en),
      .coef_rd_addr (coef_rd_addr),
      .coef_rd_data (coef_rd_data),
      .coder_init   (coder_init),
      .coder_en     (coder_en),
      .coder_coeff  (coder_coeff),
      .coder_last   (coder_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (coef_rd_en) coef_rd_data <= mem[coef_rd_addr];

   always @(negedge clk) begin
      if (reset_n) begin
         if (coef_rd_en) begin
            rd_addr_q.push_back(int'(coef_rd_addr));
            rd_cyc_q.push_back(cyc);
            if (pause) pause_rd++;
         end
         if (coder_en) begin
            en_cyc_q.push_back(cyc);
            coeff_q.push_back(coder_coeff);
            last_q.push_back(coder_last);
         end
         if (coder_init) init_q.push_back(cyc);
         if (done) begin
            done_q.push_back(cyc);
            err_log.push_back(cfg_err);
         end
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      en_cyc_q.delete();
      coeff_q.delete();
      last_q.delete();
      init_q.delete();
      done_q.delete();
      err_log.delete();
      pause_rd  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic launch(input int nb, input bit il, output int t);
      start      = 1'b1;
      num_blocks = 6'(nb);
      interlaced = il;
      t          = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_q.size() == 0; i++) tick();
      repeat (3) tick();
   endtask

   // Counts deviations of the logged slice from the scan-order model.
   function automatic int stream_errs(input int nb, input bit il);
      int e;
      int a;
      e = 0;
      if (rd_addr_q.size() != 63 * nb) return 1000;
      if (coeff_q.size() != 63 * nb) return 1000;
      for (int k = 0; k < 63 * nb; k++) begin
         a = (k % nb) * 64 + (il ? intl_t[k / nb + 1] : prog_t[k / nb + 1]);
         if (rd_addr_q[k] != a) e++;
         if (coeff_q[k] !== mem[a]) e++;
         if (last_q[k] != (k == 63 * nb - 1)) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      total++;
      if ({busy, done, cfg_err, coef_rd_en, coder_init,
           coder_en, coder_last} !== 7'b0)
         $display("FAIL reset_ctl: got %b want 0",
            {busy, done, cfg_err, coef_rd_en, coder_init,
             coder_en, coder_last});
      else passed++;
      reset_n = 1'b1;
      repeat (2) tick();
      total++;
      if (coef_rd_addr !== 11'd0 || coder_coeff !== 32'd0)
         $display("FAIL reset_data: got addr %0d coeff %0d want 0 0",
            coef_rd_addr, coder_coeff);
      else passed++;
      total++;
      if (busy !== 1'b0)
         $display("FAIL reset_busy: got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_prog_nb2();
      int t;
      clear_logs();
      launch(2, 1'b0, t);
      repeat (9) tick();
      // start while busy must be ignored
      start = 1'b1;
      num_blocks = 6'd1;
      tick();
      start = 1'b0;
      wait_done(200);
      total++;
      if (rd_addr_q.size() != 126)
         $display("FAIL p2_reads: got %0d want 126", rd_addr_q.size());
      else passed++;
      total++;
      if (rd_addr_q[0] != 1 || rd_addr_q[1] != 65 || rd_addr_q[2] != 8 ||
          rd_addr_q[3] != 72 || rd_addr_q[4] != 9 || rd_addr_q[5] != 73)
         $display("FAIL p2_head: got %0d %0d %0d %0d want 1 65 8 72",
            rd_addr_q[0], rd_addr_q[1], rd_addr_q[2], rd_addr_q[3]);
      else passed++;
      total++;
      if (rd_addr_q[124] != 63 || rd_addr_q[125] != 127)
         $display("FAIL p2_tail: got %0d %0d want 63 127",
            rd_addr_q[124], rd_addr_q[125]);
      else passed++;
      total++;
      if (rd_cyc_q[0] != t + 2 || rd_cyc_q[125] != t + 127)
         $display("FAIL p2_rd_time: got %0d..%0d want %0d..%0d",
            rd_cyc_q[0], rd_cyc_q[125], t + 2, t + 127);
      else passed++;
      total++;
      if (en_cyc_q.size() != 126 || en_cyc_q[0] != t + 4)
         $display("FAIL p2_en: got n=%0d first=%0d want 126 %0d",
            en_cyc_q.size(), en_cyc_q[0], t + 4);
      else passed++;
      total++;
      if (stream_errs(2, 1'b0) != 0)
         $display("FAIL p2_stream: got %0d errors want 0",
            stream_errs(2, 1'b0));
      else passed++;
      total++;
      if (init_q.size() != 1 || init_q[0] != t + 1)
         $display("FAIL p2_init: got n=%0d at %0d want 1 at %0d",
            init_q.size(), init_q[0], t + 1);
      else passed++;
      total++;
      if (done_q.size() != 1 || done_q[0] != t + 135 || err_log[0])
         $display("FAIL p2_done: got n=%0d at %0d want 1 at %0d",
            done_q.size(), done_q[0], t + 135);
      else passed++;
      total++;
      if (busy !== 1'b0)
         $display("FAIL p2_idle: got busy %b want 0", busy);
      else passed++;
   endtask

   task automatic test_intl_nb1();
      int t;
      clear_logs();
      launch(1, 1'b1, t);
      // pause during INIT has no effect
      pause = 1'b1;
      tick();
      pause = 1'b0;
      wait_done(120);
      total++;
      if (rd_addr_q[0] != 8 || rd_addr_q[1] != 1)
         $display("FAIL i1_head: got %0d %0d want 8 1",
            rd_addr_q[0], rd_addr_q[1]);
      else passed++;
      total++;
      if (init_q.size() != 1 || init_q[0] != t + 1)
         $display("FAIL i1_init: got n=%0d at %0d want 1 at %0d",
            init_q.size(), init_q[0], t + 1);
      else passed++;
      total++;
      if (stream_errs(1, 1'b1) != 0)
         $display("FAIL i1_stream: got %0d errors want 0",
            stream_errs(1, 1'b1));
      else passed++;
      total++;
      if (done_q.size() != 1 || done_q[0] != t + 72)
         $display("FAIL i1_done: got n=%0d at %0d want 1 at %0d",
            done_q.size(), done_q[0], t + 72);
      else passed++;
   endtask

   task automatic test_pause();
      int t;
      clear_logs();
      launch(4, 1'b0, t);
      repeat (29) tick();
      pause = 1'b1;
      repeat (5) tick();
      pause = 1'b0;
      wait_done(400);
      total++;
      if (pause_rd != 0)
         $display("FAIL pz_reads: got %0d paused reads want 0", pause_rd);
      else passed++;
      total++;
      if (rd_cyc_q[27] != t + 29 || rd_cyc_q[28] != t + 35)
         $display("FAIL pz_gap: got %0d %0d want %0d %0d",
            rd_cyc_q[27], rd_cyc_q[28], t + 29, t + 35);
      else passed++;
      total++;
      if (stream_errs(4, 1'b0) != 0)
         $display("FAIL pz_stream: got %0d errors want 0",
            stream_errs(4, 1'b0));
      else passed++;
      total++;
      if (done_q.size() != 1 || done_q[0] != t + 266)
         $display("FAIL pz_done: got n=%0d at %0d want 1 at %0d",
            done_q.size(), done_q[0], t + 266);
      else passed++;
   endtask

   task automatic test_cfg_err();
      int t;
      int bad [2] = '{0, 33};
      foreach (bad[i]) begin
         clear_logs();
         launch(bad[i], 1'b0, t);
         repeat (6) tick();
         total++;
         if (done_q.size() != 1 || done_q[0] != t + 1 || !err_log[0])
            $display("FAIL cfg_%0d_done: got n=%0d at %0d want 1 at %0d",
               bad[i], done_q.size(), done_q[0], t + 1);
         else passed++;
         total++;
         if (rd_addr_q.size() != 0 || busy_seen)
            $display("FAIL cfg_%0d_quiet: got reads %0d busy %b want 0 0",
               bad[i], rd_addr_q.size(), busy_seen);
         else passed++;
      end
   endtask

   task automatic test_max_blocks();
      int t;
      clear_logs();
      launch(32, 1'b0, t);
      wait_done(2100);
      total++;
      if (rd_addr_q.size() != 2016 || rd_addr_q[2015] != 2047)
         $display("FAIL mx_reads: got n=%0d last %0d want 2016 2047",
            rd_addr_q.size(), rd_addr_q[2015]);
      else passed++;
      total++;
      if (stream_errs(32, 1'b0) != 0)
         $display("FAIL mx_stream: got %0d errors want 0",
            stream_errs(32, 1'b0));
      else passed++;
      total++;
      if (done_q.size() != 1 || done_q[0] != t + 2025 || err_log[0])
         $display("FAIL mx_done: got n=%0d at %0d want 1 at %0d",
            done_q.size(), done_q[0], t + 2025);
      else passed++;
   endtask

   task automatic test_abort();
      int t;
      int late;
      clear_logs();
      launch(2, 1'b0, t);
      while (cyc < t + 41) tick();
      abort      = 1'b1;
      start      = 1'b1;
      num_blocks = 6'd2;
      tick();
      abort = 1'b0;
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || coef_rd_en !== 1'b0)
         $display("FAIL ab_idle: got busy %b rd %b want 0 0",
            busy, coef_rd_en);
      else passed++;
      repeat (20) tick();
      late = 0;
      foreach (en_cyc_q[i]) if (en_cyc_q[i] > t + 41) late++;
      total++;
      if (late > 1)
         $display("FAIL ab_inflight: got %0d want <=1", late);
      else passed++;
      total++;
      if (done_q.size() != 0 || init_q.size() != 1)
         $display("FAIL ab_nodone: got done %0d init %0d want 0 1",
            done_q.size(), init_q.size());
      else passed++;
      total++;
      if (rd_addr_q.size() > 40)
         $display("FAIL ab_reads: got %0d want <=40", rd_addr_q.size());
      else passed++;
      clear_logs();
      launch(2, 1'b0, t);
      wait_done(200);
      total++;
      if (stream_errs(2, 1'b0) != 0 || done_q.size() != 1 ||
          done_q[0] != t + 135)
         $display("FAIL ab_rerun: got %0d errors done at %0d want 0 %0d",
            stream_errs(2, 1'b0), done_q[0], t + 135);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int t;
      clear_logs();
      launch(2, 1'b0, t);
      repeat (50) tick();
      reset_n = 1'b0;
      #1;
      total++;
      if ({busy, done, cfg_err, coef_rd_en, coder_init, coder_en,
           coder_last} !== 7'b0 || coef_rd_addr !== 11'd0 ||
          coder_coeff !== 32'd0)
         $display("FAIL rm_zero: got ctl %b addr %0d want 0 0",
            {busy, done, cfg_err, coef_rd_en, coder_init, coder_en,
             coder_last}, coef_rd_addr);
      else passed++;
      tick();
      reset_n = 1'b1;
      tick();
      clear_logs();
      launch(2, 1'b0, t);
      wait_done(200);
      total++;
      if (stream_errs(2, 1'b0) != 0)
         $display("FAIL rm_stream: got %0d errors want 0",
            stream_errs(2, 1'b0));
      else passed++;
      total++;
      if (done_q.size() != 1 || done_q[0] != t + 135 ||
          init_q.size() != 1 || en_cyc_q[0] != t + 4)
         $display("FAIL rm_timing: got done %0d en0 %0d want %0d %0d",
            done_q[0], en_cyc_q[0], t + 135, t + 4);
      else passed++;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++)
         mem[i] = (i % 5 == 0) ? 32'd0
                : (i % 2 == 1) ? 32'(-(i * 3)) : 32'(i * 11 + 1);
      coef_rd_data = 32'd0;
      start        = 1'b0;
      num_blocks   = 6'd0;
      interlaced   = 1'b0;
      abort        = 1'b0;
      pause        = 1'b0;
      reset_n      = 1'b0;
      tick();
      test_reset();
      test_prog_nb2();
      test_intl_nb1();
      test_pause();
      test_cfg_err();
      test_max_blocks();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
